// File: rtl/dmem_param.sv
// Parametrised single-port data RAM with a hardware zero-fill sequencer; read is 0-cycle (READ_MODE=0) or 1-cycle (READ_MODE=1).
// Backpressure: busy is high while the clear runs, and every access presented during that time is dropped.
module dmem_param #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int READ_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              E,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DI,
  input  logic              clr,
  output logic [DATA_W-1:0] DO,
  output logic              rd_valid,
  output logic              busy
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_STATE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        // Single pass: the edge that zeroes the last word returns to IDLE.
        if (&clr_addr) begin
          state_nxt    = IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        clr_addr_nxt = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_en = !busy && E && WE && !clr;

  // Array has no reset; the sequencer is the only way to zero it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[Addr] <= DI;
    end
  end

  generate
    if (READ_MODE == 0) begin : g_comb_rd
      assign DO       = (E && !busy) ? mem[Addr] : '0;
      assign rd_valid = E && !busy && !WE;
    end else begin : g_reg_rd
      logic rd_acc;
      assign rd_acc = E && !WE && !busy && !clr;

      // DO holds the last accepted read; write cycles never load it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          DO       <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            DO <= mem[Addr];
          end
        end
      end
    end
  endgenerate

endmodule
